// File: rtl/vga_mode_sequencer.sv
// VGA raster timing generator with a 4-entry mode table. A requested mode is
// adopted only at the last pixel of a frame, so every frame on the wire is whole.
module vga_mode_sequencer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [1:0]    mode_req,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [1:0]    mode_active
);

    typedef struct packed {
        logic [CW-1:0] ha;
        logic [CW-1:0] hfp;
        logic [CW-1:0] hs;
        logic [CW-1:0] ht;
        logic [CW-1:0] va;
        logic [CW-1:0] vfp;
        logic [CW-1:0] vs;
        logic [CW-1:0] vt;
        logic          hpol;
        logic          vpol;
    } timing_t;

    // Polarity bit is the asserted level of the sync pulse (1 = active-high).
    function automatic timing_t mk_timing(input int ha, input int hfp, input int hs, input int hbp,
                                          input int va, input int vfp, input int vs, input int vbp,
                                          input logic hp, input logic vp);
        timing_t t;
        t.ha   = CW'(ha);
        t.hfp  = CW'(hfp);
        t.hs   = CW'(hs);
        t.ht   = CW'(ha + hfp + hs + hbp);
        t.va   = CW'(va);
        t.vfp  = CW'(vfp);
        t.vs   = CW'(vs);
        t.vt   = CW'(va + vfp + vs + vbp);
        t.hpol = hp;
        t.vpol = vp;
        return t;
    endfunction

    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0:    t = mk_timing(640, 16,  96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            2'd1:    t = mk_timing(640, 16,  96, 48, 400, 12, 2, 35, 1'b0, 1'b1);
            2'd2:    t = mk_timing(720, 18, 108, 54, 400, 12, 2, 35, 1'b0, 1'b1);
            default: t = mk_timing( 16,  2,   4,  2,   8,  1, 2,  1, 1'b1, 1'b1);
        endcase
        return t;
    endfunction

    logic [CW-1:0] h_p0;
    logic [CW-1:0] v_p0;
    logic [1:0]    mode_p0;
    timing_t       cur_p0;
    logic [CW-1:0] hs_lo_p0, hs_hi_p0, vs_lo_p0, vs_hi_p0;
    logic          h_last_p0, v_last_p0, h_act_p0, v_act_p0, h_sync_p0, v_sync_p0;

    // Stage p0: decode the current counter position under the active mode.
    always_comb begin
        cur_p0    = mode_timing(mode_p0);
        hs_lo_p0  = cur_p0.ha + cur_p0.hfp;
        hs_hi_p0  = hs_lo_p0 + cur_p0.hs;
        vs_lo_p0  = cur_p0.va + cur_p0.vfp;
        vs_hi_p0  = vs_lo_p0 + cur_p0.vs;
        h_last_p0 = (h_p0 == cur_p0.ht - CW'(1));
        v_last_p0 = (v_p0 == cur_p0.vt - CW'(1));
        h_act_p0  = (h_p0 < cur_p0.ha);
        v_act_p0  = (v_p0 < cur_p0.va);
        h_sync_p0 = (h_p0 >= hs_lo_p0) && (h_p0 < hs_hi_p0);
        v_sync_p0 = (v_p0 >= vs_lo_p0) && (v_p0 < vs_hi_p0);
    end

    // Stage p1: registered outputs; counters and mode advance on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_p0        <= '0;
            v_p0        <= '0;
            mode_p0     <= 2'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            mode_active <= 2'd0;
        end else if (enable) begin
            hsync       <= h_sync_p0 ? cur_p0.hpol : ~cur_p0.hpol;
            vsync       <= v_sync_p0 ? cur_p0.vpol : ~cur_p0.vpol;
            de          <= h_act_p0 && v_act_p0;
            x           <= (h_act_p0 && v_act_p0) ? h_p0 : '0;
            y           <= v_act_p0 ? v_p0 : '0;
            line_start  <= (h_p0 == '0);
            frame_start <= (h_p0 == '0) && (v_p0 == '0);
            mode_active <= mode_p0;
            if (h_last_p0) begin
                h_p0 <= '0;
                if (v_last_p0) begin
                    v_p0    <= '0;
                    mode_p0 <= mode_req;
                end else begin
                    v_p0 <= v_p0 + CW'(1);
                end
            end else begin
                h_p0 <= h_p0 + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: a frame-position model (linear pixel index per
// frame, timing from the mode table) predicts every output on every edge.
module tb_vga_mode_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode_req;
    logic       hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
    logic [1:0] mode_active;

    vga_mode_sequencer #(.CW(10)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode_req(mode_req),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .mode_active(mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Mode table as regions: active, front porch, sync, back porch; polarity = asserted level.
    int HA[4]   = '{640, 640, 720, 16};
    int HFP[4]  = '{16, 16, 18, 2};
    int HS[4]   = '{96, 96, 108, 4};
    int HBP[4]  = '{48, 48, 54, 2};
    int VA[4]   = '{480, 400, 400, 8};
    int VFP[4]  = '{10, 12, 12, 1};
    int VS[4]   = '{2, 2, 2, 2};
    int VBP[4]  = '{33, 35, 35, 1};
    int HPOL[4] = '{0, 0, 0, 1};
    int VPOL[4] = '{0, 1, 1, 1};

    int m_mode, m_pos;
    int e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_mode;
    int n_assert = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_mode = 0; m_pos = 0;
        e_hs = 1; e_vs = 1; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0; e_mode = 0;
    endtask

    task automatic model_edge(input bit en, input logic [1:0] req);
        int ht, vt, h, v;
        if (!en) return;
        ht = HA[m_mode] + HFP[m_mode] + HS[m_mode] + HBP[m_mode];
        vt = VA[m_mode] + VFP[m_mode] + VS[m_mode] + VBP[m_mode];
        h = m_pos % ht;
        v = m_pos / ht;
        e_de = (h < HA[m_mode] && v < VA[m_mode]) ? 1 : 0;
        e_x  = e_de ? h : 0;
        e_y  = (v < VA[m_mode]) ? v : 0;
        e_hs = (h >= HA[m_mode] + HFP[m_mode] && h < HA[m_mode] + HFP[m_mode] + HS[m_mode])
               ? HPOL[m_mode] : 1 - HPOL[m_mode];
        e_vs = (v >= VA[m_mode] + VFP[m_mode] && v < VA[m_mode] + VFP[m_mode] + VS[m_mode])
               ? VPOL[m_mode] : 1 - VPOL[m_mode];
        e_ls = (h == 0) ? 1 : 0;
        e_fs = (m_pos == 0) ? 1 : 0;
        e_mode = m_mode;
        m_pos++;
        if (m_pos == ht * vt) begin
            m_pos = 0;
            m_mode = int'(req);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("hsync", 32'(hsync), e_hs);
        chk("vsync", 32'(vsync), e_vs);
        chk("de", 32'(de), e_de);
        chk("x", 32'(x), e_x);
        chk("y", 32'(y), e_y);
        chk("line_start", 32'(line_start), e_ls);
        chk("frame_start", 32'(frame_start), e_fs);
        chk("mode_active", 32'(mode_active), e_mode);
    endtask

    task automatic step(input bit en, input logic [1:0] req);
        enable = en;
        mode_req = req;
        @(posedge clk);
        model_edge(en, req);
        #1;
        check_all();
    endtask

    initial begin
        logic [1:0] r;
        bit en;
        int fs_n, ls_n, de_n, hs_n, vs_n, xmax, ymax, de_line, full_lines;
        int ls_bad, hs_bad, vs_bad, last_ls, en_cnt, found, hl0, first_low, vs_first;

        rst_n = 1'b1; enable = 1'b0; mode_req = 2'd0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all();

        // First frame after release runs mode 0 whatever is requested mid-frame.
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 420001; i++) begin
            r = (i < 419000) ? 2'($urandom_range(0, 3)) : 2'd3;
            step(1'b1, r);
            if (i == 1) begin
                chk("first_edge_fs", 32'(frame_start), 1);
                chk("first_edge_de", 32'(de), 1);
            end
            if (i == 420000) chk("mode_before_switch", 32'(mode_active), 0);
            if (i == 420001) begin
                chk("mode_after_switch", 32'(mode_active), 3);
                chk("fs_with_switch", 32'(frame_start), 1);
            end
        end

        // Mode 3 steady-state frame statistics, outputs at positions 0..287.
        fs_n = 0; ls_n = 0; de_n = 0; hs_n = 0; vs_n = 0; xmax = 0; ymax = 0;
        de_line = 0; full_lines = 0; ls_bad = 0; hs_bad = 0; vs_bad = 0; last_ls = 0;
        for (int k = 0; k < 288; k++) begin
            if (line_start) begin
                ls_n++;
                if (k > 0 && k - last_ls != 24) ls_bad++;
                if (k > 0 && de_line == 16) full_lines++;
                last_ls = k;
                de_line = 0;
            end
            if (frame_start) fs_n++;
            if (de) begin de_n++; de_line++; end
            if (hsync) hs_n++;
            if (vsync) vs_n++;
            if (hsync !== ((k % 24) >= 18 && (k % 24) <= 21)) hs_bad++;
            if (vsync !== ((k / 24) >= 9 && (k / 24) <= 10)) vs_bad++;
            if (int'(x) > xmax) xmax = int'(x);
            if (int'(y) > ymax) ymax = int'(y);
            step(1'b1, 2'd3);
        end
        if (de_line == 16) full_lines++;
        chk("m3_fs_period", 32'(frame_start), 1);
        chk("m3_fs_count", fs_n, 1);
        chk("m3_ls_count", ls_n, 12);
        chk("m3_ls_gap_bad", ls_bad, 0);
        chk("m3_de_cycles", de_n, 128);
        chk("m3_de_full_lines", full_lines, 8);
        chk("m3_hsync_high", hs_n, 48);
        chk("m3_hsync_place_bad", hs_bad, 0);
        chk("m3_vsync_high", vs_n, 48);
        chk("m3_vsync_place_bad", vs_bad, 0);
        chk("m3_xmax", xmax, 15);
        chk("m3_ymax", ymax, 7);

        // A request that reverts before the boundary leaves the mode alone.
        for (int k = 1; k <= 288; k++) begin
            r = (k >= 100 && k < 200) ? 2'd1 : 2'd3;
            step(1'b1, r);
        end
        chk("revert_fs", 32'(frame_start), 1);
        chk("revert_mode", 32'(mode_active), 3);

        // Freeze mid-line, then finish the frame with random enable gaps.
        for (int k = 1; k <= 5; k++) step(1'b1, 2'd3);
        chk("pre_freeze_x", 32'(x), 5);
        for (int k = 0; k < 50; k++) step(1'b0, 2'd3);
        chk("frozen_x", 32'(x), 5);
        chk("frozen_de", 32'(de), 1);
        step(1'b1, 2'd3);
        chk("resume_x", 32'(x), 6);
        en_cnt = 6; found = 0;
        for (int k = 0; k < 3000 && found == 0; k++) begin
            en = ($urandom_range(0, 3) != 0);
            step(en, 2'd3);
            if (en) begin
                en_cnt++;
                if (frame_start) found = 1;
            end
        end
        chk("gap_frame_found", found, 1);
        chk("gap_frame_len", en_cnt, 288);

        // Switch to mode 2 requested mid-frame; current mode 3 frame completes untouched.
        for (int k = 1; k <= 288; k++) begin
            r = (k >= 50) ? 2'd2 : 2'd3;
            step(1'b1, r);
            if (k == 150) chk("m2_pending_mode", 32'(mode_active), 3);
        end
        chk("m2_fs", 32'(frame_start), 1);
        chk("m2_mode", 32'(mode_active), 2);
        ls_n = 0; ls_bad = 0; last_ls = 0; hl0 = 0; first_low = -1; vs_n = 0; vs_first = -1;
        for (int k = 0; k < 900 * 415; k++) begin
            if (line_start) begin
                ls_n++;
                if (k > 0 && k - last_ls != 900) ls_bad++;
                last_ls = k;
            end
            if (k < 900 && !hsync) begin
                hl0++;
                if (first_low < 0) first_low = k;
            end
            if (vsync) begin
                vs_n++;
                if (vs_first < 0) vs_first = k;
            end
            step(1'b1, 2'($urandom_range(0, 3)));
        end
        chk("m2_ls_count", ls_n, 415);
        chk("m2_ls_gap_bad", ls_bad, 0);
        chk("m2_hsync_low_cycles", hl0, 108);
        chk("m2_hsync_first_low", first_low, 738);
        chk("m2_vsync_high_cycles", vs_n, 1800);
        chk("m2_vsync_first_high", vs_first, 412 * 900);

        // Asynchronous reset mid-frame, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_de", 32'(de), 0);
        chk("async_hsync", 32'(hsync), 1);
        chk("async_vsync", 32'(vsync), 1);
        chk("async_mode", 32'(mode_active), 0);
        @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 2'd1);
        chk("restart_fs", 32'(frame_start), 1);
        chk("restart_ls", 32'(line_start), 1);
        chk("restart_xy", 32'({x, y}), 0);
        for (int k = 0; k < 2000; k++) step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
